// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, opcode map and the writeback
// result-source classification reused by decode, hazard and writeback logic.
package cpu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREGS  = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned OP_W   = 6;
    localparam int unsigned CNT_W  = 32;

    localparam logic [OP_W-1:0] OP_NOP    = 6'h00;
    localparam logic [OP_W-1:0] OP_ALU_LO = 6'h01;
    localparam logic [OP_W-1:0] OP_ALU_HI = 6'h0F;
    localparam logic [OP_W-1:0] OP_ADDP   = 6'h10;
    localparam logic [OP_W-1:0] OP_MUL    = 6'h11;
    localparam logic [OP_W-1:0] OP_LOAD   = 6'h20;
    localparam logic [OP_W-1:0] OP_STORE  = 6'h21;
    localparam logic [OP_W-1:0] OP_LI     = 6'h30;
    localparam logic [OP_W-1:0] OP_MOV    = 6'h31;

    typedef enum logic [2:0] {
        SRC_ALU,
        SRC_SUM,
        SRC_MUL,
        SRC_LOAD,
        SRC_IMM,
        SRC_RS1
    } wb_src_e;

    // Unlisted opcodes (NOP, STORE, holes) fall back to the ALU result.
    function automatic wb_src_e result_src(input logic [OP_W-1:0] op);
        wb_src_e src;
        src = SRC_ALU;
        case (op)
            OP_ADDP: src = SRC_SUM;
            OP_MUL:  src = SRC_MUL;
            OP_LOAD: src = SRC_LOAD;
            OP_LI:   src = SRC_IMM;
            OP_MOV:  src = SRC_RS1;
            default: src = SRC_ALU;
        endcase
        return src;
    endfunction

    // Opcodes that never update the register file even with we asserted.
    function automatic logic writes_reg(input logic [OP_W-1:0] op);
        return (op != OP_NOP) && (op != OP_STORE);
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register file: one write port, two read ports with
// same-cycle write-through bypass; entry 0 always reads as zero.
module regfile_2r1w
    import cpu_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [REG_AW-1:0] raddr_a_i,
    input  logic [REG_AW-1:0] raddr_b_i,
    output logic [XLEN-1:0]   rdata_a_o,
    output logic [XLEN-1:0]   rdata_b_o
);

    logic [XLEN-1:0] mem_q [NREGS];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_a_o = mem_q[raddr_a_i];
        if (raddr_a_i == '0) begin
            rdata_a_o = '0;
        end else if (we_i && (raddr_a_i == waddr_i)) begin
            rdata_a_o = wdata_i;
        end
    end

    always_comb begin
        rdata_b_o = mem_q[raddr_b_i];
        if (raddr_b_i == '0) begin
            rdata_b_o = '0;
        end else if (we_i && (raddr_b_i == waddr_i)) begin
            rdata_b_o = wdata_i;
        end
    end

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage: selects the result for the retiring instruction, commits it
// to the register file and tracks retired/written counts for performance runs.
module writeback_regfile
    import cpu_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [XLEN-1:0]   reg_rs1_d3,
    input  logic [XLEN-1:0]   alu_out_d3,
    input  logic [XLEN-1:0]   immediate_value_d3,
    input  logic [XLEN-1:0]   DOut_d3,
    input  logic [XLEN-1:0]   sum_d3,
    input  logic [XLEN-1:0]   multiply_d3,
    input  logic [OP_W-1:0]   opcode_d3,
    input  logic [REG_AW-1:0] rd_d3,
    input  logic              register_we_d3,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    output logic [XLEN-1:0]   rs1_data,
    output logic [XLEN-1:0]   rs2_data,
    output logic [XLEN-1:0]   wb_data,
    output logic              wb_fire,
    output logic [REG_AW-1:0] last_rd,
    output logic [XLEN-1:0]   last_data,
    output logic [CNT_W-1:0]  retired_count,
    output logic [CNT_W-1:0]  write_count
);

    logic [CNT_W-1:0]  retired_q, retired_d;
    logic [CNT_W-1:0]  writes_q, writes_d;
    logic [REG_AW-1:0] last_rd_q, last_rd_d;
    logic [XLEN-1:0]   last_data_q, last_data_d;

    always_comb begin
        wb_data = alu_out_d3;
        case (result_src(opcode_d3))
            SRC_SUM:  wb_data = sum_d3;
            SRC_MUL:  wb_data = multiply_d3;
            SRC_LOAD: wb_data = DOut_d3;
            SRC_IMM:  wb_data = immediate_value_d3;
            SRC_RS1:  wb_data = reg_rs1_d3;
            default:  wb_data = alu_out_d3;
        endcase
    end

    assign wb_fire = register_we_d3 && (rd_d3 != '0) && writes_reg(opcode_d3);

    regfile_2r1w u_regfile (
        .clk_i     (clock),
        .rst_i     (reset),
        .we_i      (wb_fire),
        .waddr_i   (rd_d3),
        .wdata_i   (wb_data),
        .raddr_a_i (rs1_addr),
        .raddr_b_i (rs2_addr),
        .rdata_a_o (rs1_data),
        .rdata_b_o (rs2_data)
    );

    // Counters wrap freely; last-write registers hold between commits.
    always_comb begin
        retired_d   = retired_q;
        writes_d    = writes_q;
        last_rd_d   = last_rd_q;
        last_data_d = last_data_q;
        if (opcode_d3 != OP_NOP) begin
            retired_d = retired_q + CNT_W'(1);
        end
        if (wb_fire) begin
            writes_d    = writes_q + CNT_W'(1);
            last_rd_d   = rd_d3;
            last_data_d = wb_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            retired_q   <= '0;
            writes_q    <= '0;
            last_rd_q   <= '0;
            last_data_q <= '0;
        end else begin
            retired_q   <= retired_d;
            writes_q    <= writes_d;
            last_rd_q   <= last_rd_d;
            last_data_q <= last_data_d;
        end
    end

    assign retired_count = retired_q;
    assign write_count   = writes_q;
    assign last_rd       = last_rd_q;
    assign last_data     = last_data_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed self-checking bench for writeback_regfile.
module tb_writeback_regfile;
    import cpu_pkg::*;

    logic              clock;
    logic              reset;
    logic [XLEN-1:0]   reg_rs1_d3, alu_out_d3, immediate_value_d3;
    logic [XLEN-1:0]   DOut_d3, sum_d3, multiply_d3;
    logic [OP_W-1:0]   opcode_d3;
    logic [REG_AW-1:0] rd_d3;
    logic              register_we_d3;
    logic [REG_AW-1:0] rs1_addr, rs2_addr;
    logic [XLEN-1:0]   rs1_data, rs2_data, wb_data;
    logic              wb_fire;
    logic [REG_AW-1:0] last_rd;
    logic [XLEN-1:0]   last_data;
    logic [CNT_W-1:0]  retired_count, write_count;

    int n_tests = 0;
    int n_fail  = 0;

    writeback_regfile dut (
        .clock              (clock),
        .reset              (reset),
        .reg_rs1_d3         (reg_rs1_d3),
        .alu_out_d3         (alu_out_d3),
        .immediate_value_d3 (immediate_value_d3),
        .DOut_d3            (DOut_d3),
        .sum_d3             (sum_d3),
        .multiply_d3        (multiply_d3),
        .opcode_d3          (opcode_d3),
        .rd_d3              (rd_d3),
        .register_we_d3     (register_we_d3),
        .rs1_addr           (rs1_addr),
        .rs2_addr           (rs2_addr),
        .rs1_data           (rs1_data),
        .rs2_data           (rs2_data),
        .wb_data            (wb_data),
        .wb_fire            (wb_fire),
        .last_rd            (last_rd),
        .last_data          (last_data),
        .retired_count      (retired_count),
        .write_count        (write_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Distinct background values on every source so a wrong mux leg shows up.
    task automatic idle();
        reg_rs1_d3         = 32'hA1A1_0001;
        alu_out_d3         = 32'hA2A2_0002;
        immediate_value_d3 = 32'hA3A3_0003;
        DOut_d3            = 32'hA4A4_0004;
        sum_d3             = 32'hA5A5_0005;
        multiply_d3        = 32'hA6A6_0006;
        opcode_d3          = OP_NOP;
        rd_d3              = '0;
        register_we_d3     = 1'b0;
    endtask

    task automatic present(input logic [5:0] op, input logic [4:0] rd, input logic we);
        opcode_d3      = op;
        rd_d3          = rd;
        register_we_d3 = we;
    endtask

    initial begin
        idle();
        rs1_addr = '0;
        rs2_addr = '0;
        reset    = 1'b1;
        tick();
        tick();
        rs1_addr = 5'd5;
        #1;
        check("rst_rs1", rs1_data, 32'h0);
        check("rst_last_rd", 32'(last_rd), 32'h0);
        check("rst_last_data", last_data, 32'h0);
        check("rst_wcnt", write_count, 32'h0);
        check("rst_rcnt", retired_count, 32'h0);
        reset = 1'b0;

        // LOAD writeback
        DOut_d3 = 32'hDEAD_BEEF;
        present(OP_LOAD, 5'd5, 1'b1);
        #1;
        check("load_fire", 32'(wb_fire), 32'h1);
        check("load_wbdata", wb_data, 32'hDEAD_BEEF);
        tick();
        idle();
        rs1_addr = 5'd5;
        #1;
        check("load_rd", rs1_data, 32'hDEAD_BEEF);
        check("load_last_rd", 32'(last_rd), 32'd5);
        check("load_wcnt", write_count, 32'd1);
        check("load_rcnt", retired_count, 32'd1);

        // MUL with both read ports bypassing the in-flight write
        multiply_d3 = 32'h0000_0042;
        present(OP_MUL, 5'd7, 1'b1);
        rs1_addr = 5'd7;
        rs2_addr = 5'd7;
        #1;
        check("byp_rs1", rs1_data, 32'h42);
        check("byp_rs2", rs2_data, 32'h42);
        tick();

        // LI to r0 is dropped but still retires
        idle();
        immediate_value_d3 = 32'h0000_1234;
        present(OP_LI, 5'd0, 1'b1);
        rs1_addr = 5'd0;
        #1;
        check("r0_fire", 32'(wb_fire), 32'h0);
        check("r0_read", rs1_data, 32'h0);
        tick();
        idle();
        #1;
        check("r0_wcnt", write_count, 32'd2);
        check("r0_rcnt", retired_count, 32'd3);

        // STORE with we=1 must not write
        alu_out_d3 = 32'h0000_0055;
        present(OP_STORE, 5'd3, 1'b1);
        #1;
        check("st_fire", 32'(wb_fire), 32'h0);
        tick();
        idle();
        rs1_addr = 5'd3;
        #1;
        check("st_r3", rs1_data, 32'h0);
        check("st_rcnt", retired_count, 32'd4);
        check("st_wcnt", write_count, 32'd2);

        // Back-to-back source select coverage
        sum_d3 = 32'd1;
        present(OP_ADDP, 5'd1, 1'b1);
        tick();
        idle();
        reg_rs1_d3 = 32'd2;
        present(OP_MOV, 5'd2, 1'b1);
        tick();
        idle();
        alu_out_d3 = 32'd3;
        present(6'h05, 5'd3, 1'b1);
        tick();
        idle();
        immediate_value_d3 = 32'd4;
        present(OP_LI, 5'd4, 1'b1);
        tick();
        idle();
        rs1_addr = 5'd1;
        rs2_addr = 5'd2;
        #1;
        check("sel_r1", rs1_data, 32'd1);
        check("sel_r2", rs2_data, 32'd2);
        rs1_addr = 5'd3;
        rs2_addr = 5'd4;
        #1;
        check("sel_r3", rs1_data, 32'd3);
        check("sel_r4", rs2_data, 32'd4);
        check("sel_last_data", last_data, 32'd4);
        check("sel_last_rd", 32'(last_rd), 32'd4);
        check("sel_wcnt", write_count, 32'd6);
        check("sel_rcnt", retired_count, 32'd8);

        // ALU class upper bound and an unlisted opcode both pick alu_out
        alu_out_d3 = 32'h0000_0077;
        present(OP_ALU_HI, 5'd6, 1'b0);
        #1;
        check("alu_hi_sel", wb_data, 32'h77);
        present(6'h12, 5'd6, 1'b0);
        #1;
        check("hole_sel", wb_data, 32'h77);
        idle();

        // Async reset between edges, and no commit while reset is held
        alu_out_d3 = 32'hA5A5_A5A5;
        present(6'h01, 5'd9, 1'b1);
        tick();
        idle();
        rs1_addr = 5'd9;
        #1;
        check("pre_rst_r9", rs1_data, 32'hA5A5_A5A5);
        #2;
        reset = 1'b1;
        #1;
        check("arst_r9", rs1_data, 32'h0);
        check("arst_rcnt", retired_count, 32'h0);
        check("arst_wcnt", write_count, 32'h0);
        check("arst_last_data", last_data, 32'h0);
        immediate_value_d3 = 32'h0000_0099;
        present(OP_LI, 5'd10, 1'b1);
        tick();
        tick();
        idle();
        #2;
        reset = 1'b0;
        rs1_addr = 5'd10;
        rs2_addr = 5'd9;
        #1;
        check("inrst_r10", rs1_data, 32'h0);
        check("inrst_r9", rs2_data, 32'h0);
        check("inrst_wcnt", write_count, 32'h0);
        immediate_value_d3 = 32'h0000_0099;
        present(OP_LI, 5'd10, 1'b1);
        tick();
        idle();
        #1;
        check("post_rst_r10", rs1_data, 32'h99);
        check("post_rst_wcnt", write_count, 32'd1);

        // Retired counter wraps to zero
        dut.retired_q = 32'hFFFF_FFFF;
        present(6'h02, 5'd11, 1'b0);
        tick();
        idle();
        #1;
        check("wrap_rcnt", retired_count, 32'h0);
        check("wrap_wcnt", write_count, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
